// File: rtl/mesh_pkg.sv
// Shared mesh router definitions: header field positions, one-hot port codes,
// default widths and the input-buffer slot state type.
package mesh_pkg;

   localparam int DW_DEF    = 64;
   localparam int HOP_W_DEF = 4;

   localparam int VC_BIT   = 63;
   localparam int XDIR_BIT = 62;
   localparam int YDIR_BIT = 61;
   localparam int HX_LSB   = 52;
   localparam int HX_MSB   = HX_LSB + HOP_W_DEF - 1;
   localparam int HY_LSB   = 48;
   localparam int HY_MSB   = HY_LSB + HOP_W_DEF - 1;

   typedef logic [4:0] port_t;

   localparam port_t PORT_N    = 5'b00001;
   localparam port_t PORT_E    = 5'b00010;
   localparam port_t PORT_S    = 5'b00100;
   localparam port_t PORT_W    = 5'b01000;
   localparam port_t PORT_L    = 5'b10000;
   localparam port_t PORT_NONE = 5'b00000;

   // Slot state doubles as the full flag.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } inbuf_state_t;

endpackage

// File: rtl/mesh_inbuf_route_if.sv
// Link (si/ri/di) and crossbar (req/gnt/dout) signals of one mesh input port.
// master = upstream buffer plus arbiter side, slave = the input buffer.
interface mesh_inbuf_route_if #(
   parameter int DW = 64
) ();

   logic          si;
   logic          ri;
   logic [DW-1:0] di;
   logic [4:0]    req;
   logic          gnt;
   logic [DW-1:0] dout;

   modport master (
      output si,
      output di,
      output gnt,
      input  ri,
      input  req,
      input  dout
   );

   modport slave (
      input  si,
      input  di,
      input  gnt,
      output ri,
      output req,
      output dout
   );

endinterface

// File: rtl/mesh_route_calc.sv
// Dimension-order (X then Y) route computation; returns the one-hot output
// port and the packet with the hop field of the chosen dimension decremented.
module mesh_route_calc
   import mesh_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int HOP_W = HOP_W_DEF
) (
   input  logic [DW-1:0] di,
   output port_t         route,
   output logic [DW-1:0] pkt
);

   logic [HOP_W-1:0] hx;
   logic [HOP_W-1:0] hy;

   assign hx = di[HX_LSB +: HOP_W];
   assign hy = di[HY_LSB +: HOP_W];

   // A nonzero field is decremented, so the subtraction can never wrap.
   always_comb begin
      route = PORT_L;
      pkt   = di;
      if (hx != '0) begin
         route              = di[XDIR_BIT] ? PORT_W : PORT_E;
         pkt[HX_LSB +: HOP_W] = hx - 1'b1;
      end else if (hy != '0) begin
         route              = di[YDIR_BIT] ? PORT_S : PORT_N;
         pkt[HY_LSB +: HOP_W] = hy - 1'b1;
      end
   end

endmodule

// File: rtl/mesh_inbuf_route.sv
// Single-slot mesh input buffer: captures in the external phase, requests its
// precomputed output port in the internal phase. Optional INBUF_WAIT_CNT_EN adds wait_cnt.
module mesh_inbuf_route
   import mesh_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int HOP_W = HOP_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                phase_external,
   input  logic                phase_internal,
   mesh_inbuf_route_if.slave   link,
   output logic                full
`ifdef INBUF_WAIT_CNT_EN
   ,
   output logic [7:0]          wait_cnt
`endif
);

   inbuf_state_t  state_reg, state_next;
   logic [DW-1:0] q_reg, q_next;
   port_t         route_reg, route_next;

   port_t         calc_route;
   logic [DW-1:0] calc_pkt;
   logic          req_active;

   mesh_route_calc #(
      .DW    (DW),
      .HOP_W (HOP_W)
   ) u_route_calc (
      .di    (link.di),
      .route (calc_route),
      .pkt   (calc_pkt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_EMPTY;
         q_reg     <= '0;
         route_reg <= PORT_NONE;
      end else begin
         state_reg <= state_next;
         q_reg     <= q_next;
         route_reg <= route_next;
      end
   end

   // si while full and gnt outside an active request are both dropped here.
   always_comb begin
      state_next = state_reg;
      q_next     = q_reg;
      route_next = route_reg;
      case (state_reg)
         ST_EMPTY: begin
            if (phase_external && link.si) begin
               state_next = ST_FULL;
               q_next     = calc_pkt;
               route_next = calc_route;
            end
         end
         ST_FULL: begin
            if (phase_internal && link.gnt) begin
               state_next = ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   assign full       = (state_reg == ST_FULL);
   assign req_active = phase_internal & full;
   assign link.ri    = ~full;
   assign link.req   = req_active ? route_reg : PORT_NONE;
   assign link.dout  = req_active ? q_reg : '0;

`ifdef INBUF_WAIT_CNT_EN
   logic [7:0] wait_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_reg <= '0;
      end else if (req_active && link.gnt) begin
         wait_cnt_reg <= '0;
      end else if (req_active && (wait_cnt_reg != 8'hFF)) begin
         wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end
   end

   assign wait_cnt = wait_cnt_reg;
`endif

endmodule

// File: tb/tb_mesh_inbuf_route.sv
// Self-checking bench for mesh_inbuf_route: table of packets through the
// capture/request/grant cycle plus stall, back-pressure and reset sequences.
module tb_mesh_inbuf_route;
   import mesh_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic pe;
   logic pi;
   logic full;
`ifdef INBUF_WAIT_CNT_EN
   logic [7:0] wait_cnt;
`endif

   mesh_inbuf_route_if #(.DW(64)) link ();

   always #5 clk = ~clk;

   mesh_inbuf_route dut (
      .clk            (clk),
      .reset          (reset),
      .phase_external (pe),
      .phase_internal (pi),
      .link           (link),
      .full           (full)
`ifdef INBUF_WAIT_CNT_EN
      ,
      .wait_cnt       (wait_cnt)
`endif
   );

   typedef struct {
      string       name;
      logic [63:0] di;
      logic [4:0]  req;
      logic [63:0] dout;
   } vec_t;

   typedef struct {
      logic [4:0]  req;
      logic [63:0] dout;
   } exp_t;

   vec_t vecs[7];
   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         $display("ok   %s: %h", nm, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [63:0] d);
      pe = 1'b1; link.si = 1'b1; link.di = d;
      tick();
      pe = 1'b0; link.si = 1'b0;
      #1;
   endtask

   initial begin
      vecs[0] = '{"east_x_hop",  64'h0021_0000_0000_00AB, 5'b00010, 64'h0011_0000_0000_00AB};
      vecs[1] = '{"south_y_hop", 64'h2001_0000_0000_00CD, 5'b00100, 64'h2000_0000_0000_00CD};
      vecs[2] = '{"local",       64'hC000_0000_0000_0042, 5'b10000, 64'hC000_0000_0000_0042};
      vecs[3] = '{"west_x_hop",  64'h4010_0000_1234_5678, 5'b01000, 64'h4000_0000_1234_5678};
      vecs[4] = '{"north_y_hop", 64'h000F_0000_0000_0001, 5'b00001, 64'h000E_0000_0000_0001};
      vecs[5] = '{"east_hx_max", 64'h80F3_FFFF_FFFF_FFFF, 5'b00010, 64'h80E3_FFFF_FFFF_FFFF};
      vecs[6] = '{"local_hdr",   64'h3F00_8000_0000_0000, 5'b10000, 64'h3F00_8000_0000_0000};

      reset = 1'b1; pe = 1'b0; pi = 1'b0;
      link.si = 1'b0; link.gnt = 1'b0; link.di = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("reset_ri", 64'(link.ri), 64'd1);
      chk("reset_full", 64'(full), 64'd0);
      pi = 1'b1; #1;
      chk("reset_req", 64'(link.req), 64'd0);
      chk("reset_dout", link.dout, 64'd0);
`ifdef INBUF_WAIT_CNT_EN
      chk("reset_wait_cnt", 64'(wait_cnt), 64'd0);
`endif

      // si outside the external phase must not load the slot.
      link.si = 1'b1; link.di = 64'h0021_0000_0000_0001;
      tick();
      pi = 1'b0;
      tick();
      link.si = 1'b0; #1;
      chk("si_no_phase_full", 64'(full), 64'd0);

      for (int i = 0; i < 7; i++) begin
         pe = 1'b1; link.si = 1'b1; link.di = vecs[i].di;
         #1;
         chk({vecs[i].name, "_ri_empty"}, 64'(link.ri), 64'd1);
         exp_q.push_back('{vecs[i].req, vecs[i].dout});
         tick();
         pe = 1'b0; link.si = 1'b0; #1;
         chk({vecs[i].name, "_full"}, 64'(full), 64'd1);
         chk({vecs[i].name, "_ri_full"}, 64'(link.ri), 64'd0);
         chk({vecs[i].name, "_req_nophase"}, 64'(link.req), 64'd0);
         pi = 1'b1; #1;
         e = exp_q.pop_front();
         chk({vecs[i].name, "_req"}, 64'(link.req), 64'(e.req));
         chk({vecs[i].name, "_dout"}, link.dout, e.dout);
         link.gnt = 1'b1;
         tick();
         link.gnt = 1'b0; #1;
         chk({vecs[i].name, "_full_after_gnt"}, 64'(full), 64'd0);
         chk({vecs[i].name, "_req_after_gnt"}, 64'(link.req), 64'd0);
         chk({vecs[i].name, "_dout_after_gnt"}, link.dout, 64'd0);
         pi = 1'b0;
      end

      // Stall for three internal cycles, then back-pressure and a stray grant.
      load(vecs[0].di);
      exp_q.push_back('{vecs[0].req, vecs[0].dout});
      pi = 1'b1;
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_req", 64'(link.req), 64'(e.req));
         chk("stall_dout", link.dout, e.dout);
      end
`ifdef INBUF_WAIT_CNT_EN
      chk("stall_wait_cnt", 64'(wait_cnt), 64'd3);
`endif
      pi = 1'b0; pe = 1'b1; link.si = 1'b1; link.di = vecs[1].di; link.gnt = 1'b1;
      #1;
      chk("bp_req_external", 64'(link.req), 64'd0);
      tick();
      pe = 1'b0; link.si = 1'b0; link.gnt = 1'b0; #1;
      chk("bp_full_kept", 64'(full), 64'd1);
      pi = 1'b1; #1;
      chk("bp_req_unchanged", 64'(link.req), 64'(e.req));
      chk("bp_dout_unchanged", link.dout, e.dout);
      link.gnt = 1'b1;
      tick();
      link.gnt = 1'b0; #1;
      chk("bp_full_after_gnt", 64'(full), 64'd0);
`ifdef INBUF_WAIT_CNT_EN
      chk("gnt_wait_cnt", 64'(wait_cnt), 64'd0);
`endif
      pi = 1'b0;

      // Reset while full discards the packet; the next one is accepted.
      load(vecs[3].di);
      pi = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; #1;
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_ri", 64'(link.ri), 64'd1);
      chk("rst_req", 64'(link.req), 64'd0);
      pi = 1'b0;
      load(vecs[2].di);
      exp_q.push_back('{vecs[2].req, vecs[2].dout});
      pi = 1'b1; #1;
      e = exp_q.pop_front();
      chk("post_rst_req", 64'(link.req), 64'(e.req));
      chk("post_rst_dout", link.dout, e.dout);
      link.gnt = 1'b1;
      tick();
      link.gnt = 1'b0; pi = 1'b0; #1;
      chk("post_rst_full", 64'(full), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mesh_inbuf_route.md
# mesh_inbuf_route

Single-slot input buffer with route computation for one cardinal port of the mesh router. It sits directly downstream of a neighbour's output buffer. It captures a 64-bit packet over the si/ri link handshake during the external phase, then presents a one-hot output-port request to the crossbar arbiter during the internal phase. The packet it forwards carries the hop field for its chosen dimension already decremented, and it frees its slot on grant.

## Interface
- DW, 64: packet width.
- HOP_W, 4: width of each hop-count field.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- si  in  1  link valid from the upstream output buffer. Asserted only in the upstream external phase, and only when ri=1.
- ri  out  1  ready to upstream: ~full.
- di  in  DW  link data, qualified by si.
- phase_external  in  1  link phase. Mutually exclusive with phase_internal.
- phase_internal  in  1  crossbar phase.
- req  out  5  one-hot output request {L,W,S,E,N}, i.e. bit4=L, bit3=W, bit2=S, bit1=E, bit0=N.
- gnt  in  1  arbiter grant to this input, for the current req.
- dout  out  DW  forwarded packet. Equals q when req!=0, otherwise 0.
- full  out  1  slot occupied.
- wait_cnt  out  8  present only with INBUF_WAIT_CNT_EN.

## Operation
- Header fields:
  - [63] vc: carried unchanged.
  - [62] x_dir: 0=E, 1=W.
  - [61] y_dir: 0=N, 1=S.
  - [55:52] hx.
  - [51:48] hy.
  - all other bits are carried unchanged.
- Route is computed at enqueue, X first:
  - hx!=0: route = E or W per x_dir; stored packet has hx-1.
  - else if hy!=0: route = N or S per y_dir; stored packet has hy-1.
  - else: route = L; packet stored unmodified.
- Hop decrement touches only the selected field. No underflow is possible.
- States are encoded by full:
  - EMPTY (full=0) -> FULL on `phase_external & si & ~full`. This loads q (updated packet) and route_q.
  - FULL -> EMPTY on `phase_internal & full & gnt`.
- `req = (phase_internal & full) ? route_q : 5'b0`.
- gnt while req==0 is ignored.
- si while full=1 is a protocol error and is ignored: q and route_q are unchanged.
- si outside phase_external is ignored.
- Enqueue and dequeue cannot coincide, because the phases are exclusive.

## Timing
- Reset values: full=0, q=0, route_q=0, ri=1, req=0, dout=0, wait_cnt=0.
- ri, req and dout are combinational from registers and phase inputs. There is no input-to-output combinational path except through the phase signals.
- Capture latency: the packet is captured at the posedge where si=1. req is visible in the first subsequent phase_internal cycle.
- Grant: full drops at the posedge where gnt=1. req and dout go 0 in the next cycle.
- Without a grant, req and dout are held unchanged across any number of internal-phase cycles. They are 0 during external-phase cycles.
- Reset mid-operation discards the held packet. ri=1 from the cycle after reset is sampled.

## Configuration
- INBUF_WAIT_CNT_EN defined:
  - 8-bit saturating counter; increments each cycle with req!=0 & ~gnt.
  - Clears on grant and on reset.
  - Saturates at 8'hFF.
  - Drives wait_cnt.
- INBUF_WAIT_CNT_EN undefined: counter logic and the wait_cnt port are absent. All other behaviour is identical.

## Structure
- Shared package mesh_pkg holds:
  - header bit positions: VC_BIT, XDIR_BIT, YDIR_BIT, HX_MSB/LSB, HY_MSB/LSB;
  - port one-hot constants: PORT_N/E/S/W/L;
  - DW and HOP_W defaults.
- One sub-module, mesh_route_calc: combinational, taking di and producing {route one-hot, updated packet}. It is reused by every input port.

## Test plan
- Reset, then idle → ri=1, full=0, req=0, dout=0.
- Eastbound X hop:
  - stimulus: phase_external, si=1, di=64'h0021_0000_0000_00AB;
  - response: full=1, ri=0. The next phase_internal gives req=5'b00010 and dout=64'h0011_0000_0000_00AB.
- Southbound Y hop (hx=0):
  - stimulus: di=64'h2001_0000_0000_00CD;
  - response: req=5'b00100, dout=64'h2000_0000_0000_00CD. gnt=1 gives full=0 next cycle.
- Local delivery:
  - stimulus: di=64'hC000_0000_0000_0042 (hx=hy=0);
  - response: req=5'b10000, dout identical to di.
- Stall, then back-pressure:
  - hold gnt=0 for 3 internal cycles → req and dout stable. With INBUF_WAIT_CNT_EN, wait_cnt=3, then 0 after grant.
  - si with a new packet while full → q unchanged.
- Reset while full → next cycle full=0, ri=1, req=0. A subsequent packet is accepted normally.
